lift_call_scheduler: RTL and testbench

Upstream request stage for the lift controller. Collects floor calls (cab or hall buttons) into a pending bitmap and picks the next target with a SCAN policy: keep direction while calls remain ahead, otherwise reverse. Drives the controller's req_floor and consumes its current-floor and stop outputs. Holds each served floor for a fixed door dwell before moving on.

---
 rtl/lift_call_scheduler.sv | 139 +++++++++++++
 tb/tb_lift_call_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: collects floor calls and feeds the lift controller SCAN targets with a door dwell.
// Define LIFT_HOME_RETURN_EN to send an idle lift back to floor 0 after HOME_TIMEOUT clocks.
module lift_call_scheduler #(
  parameter int NUM_FLOORS = 31,
  parameter int FLOOR_W = 6,
  parameter int DWELL_CYCLES = 4,
  parameter int HOME_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic call_valid,
  input  logic [FLOOR_W-1:0] call_floor,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic lift_stop,
  output logic [FLOOR_W-1:0] req_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic dir_up,
  output logic busy,
  output logic call_err
);
  typedef enum logic [1:0] {IDLE, MOVING, DWELL} state_t;
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [FLOOR_W-1:0] LIMIT = FLOOR_W'(NUM_FLOORS);
  state_t state;
  logic [CW-1:0] dwell_cnt;
  logic [FLOOR_W-1:0] up_t, dn_t, tgt;
  logic up_found, dn_found, has_tgt, tgt_up, call_ok, cur_pend, arrived, stop_clr, absorb, pick_up;
  logic [NUM_FLOORS-1:0] cur_mask, call_mask, req_mask, set_mask, clr_mask;
`ifdef LIFT_HOME_RETURN_EN
  localparam int IW = $clog2(HOME_TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  logic homing;
  assign stop_clr = arrived && !homing;
`else
  assign stop_clr = arrived;
`endif
  // nearest pending floor strictly above and strictly below the cab
  always_comb begin
    up_t = '0;
    dn_t = '0;
    up_found = 1'b0;
    dn_found = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && FLOOR_W'(i) > cur_floor) begin
        up_t = FLOOR_W'(i);
        up_found = 1'b1;
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && FLOOR_W'(i) < cur_floor) begin
        dn_t = FLOOR_W'(i);
        dn_found = 1'b1;
      end
  end
  assign has_tgt = up_found || dn_found;
  assign tgt_up = dir_up ? up_found : !dn_found;
  assign tgt = tgt_up ? up_t : dn_t;
  assign cur_mask = NUM_FLOORS'(1) << cur_floor;
  assign call_mask = NUM_FLOORS'(1) << call_floor;
  assign req_mask = NUM_FLOORS'(1) << req_floor;
  assign call_ok = call_valid && call_floor < LIMIT;
  assign cur_pend = |(pending & cur_mask);
  assign arrived = cur_floor == req_floor && lift_stop;
  assign absorb = state == DWELL && call_ok && call_floor == cur_floor;
  assign pick_up = dir_up ? up_found && up_t < req_floor : dn_found && dn_t > req_floor;
  assign clr_mask = state == IDLE && cur_pend ? cur_mask : state == MOVING && stop_clr ? req_mask : '0;
  assign set_mask = call_ok && !absorb ? call_mask : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pending <= '0;
      req_floor <= '0;
      dir_up <= 1'b1;
      busy <= 1'b0;
      call_err <= 1'b0;
      dwell_cnt <= '0;
`ifdef LIFT_HOME_RETURN_EN
      idle_cnt <= '0;
      homing <= 1'b0;
`endif
    end else begin
      call_err <= call_valid && !(call_floor < LIMIT);
      pending <= (pending | set_mask) & ~clr_mask;
`ifdef LIFT_HOME_RETURN_EN
      idle_cnt <= state == IDLE && pending == '0 && !call_ok && cur_floor != '0 &&
                  idle_cnt != IW'(HOME_TIMEOUT - 1) ? idle_cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE:
          if (cur_pend) begin
            state <= DWELL;
            dwell_cnt <= CW'(DWELL_CYCLES - 1);
            busy <= 1'b1;
            req_floor <= cur_floor;
          end else if (has_tgt) begin
            state <= MOVING;
            req_floor <= tgt;
            dir_up <= tgt_up;
            busy <= 1'b1;
          end
`ifdef LIFT_HOME_RETURN_EN
          else if (cur_floor != '0 && idle_cnt == IW'(HOME_TIMEOUT - 1)) begin
            state <= MOVING;
            req_floor <= '0;
            dir_up <= 1'b0;
            busy <= 1'b1;
            homing <= 1'b1;
          end
`endif
          else req_floor <= cur_floor;
        MOVING:
          if (stop_clr) begin
            state <= DWELL;
            dwell_cnt <= CW'(DWELL_CYCLES - 1);
          end
`ifdef LIFT_HOME_RETURN_EN
          else if (homing && arrived) begin
            state <= IDLE;
            busy <= 1'b0;
            homing <= 1'b0;
          end else if (homing && has_tgt) begin
            req_floor <= tgt;
            dir_up <= tgt_up;
            homing <= 1'b0;
          end
`endif
          else if (pick_up) req_floor <= dir_up ? up_t : dn_t;
        DWELL: begin
          req_floor <= cur_floor;
          if (absorb) dwell_cnt <= CW'(DWELL_CYCLES - 1);
          else if (dwell_cnt == '0) begin
            state <= IDLE;
            busy <= 1'b0;
          end else dwell_cnt <= dwell_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb_lift_call_scheduler: random calls and a simple lift cab, checked against a floor-walking reference model.
module tb_lift_call_scheduler;
  localparam int NF = 31;
  localparam int FW = 6;
  localparam int DW = 4;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DWELL = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic call_valid = 1'b0;
  logic lift_stop = 1'b1;
  logic [FW-1:0] call_floor = '0;
  logic [FW-1:0] cur_floor = '0;
  logic [FW-1:0] req_floor;
  logic [NF-1:0] pending;
  logic dir_up, busy, call_err;
  int checks = 0;
  int errors = 0;
  bit pend[NF];
  int m_mode, m_req, m_left, cur_i, mv;
  bit m_up, m_busy, m_err;

  always #5 clk = ~clk;

  lift_call_scheduler dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .cur_floor(cur_floor), .lift_stop(lift_stop), .req_floor(req_floor),
    .pending(pending), .dir_up(dir_up), .busy(busy), .call_err(call_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_mode = M_IDLE;
    m_req = 0;
    m_up = 1'b1;
    m_busy = 1'b0;
    m_err = 1'b0;
    m_left = 0;
  endtask

  // walk outward from a floor in one direction until a pending call is met
  function automatic bit seek(input int from, input bit up, output int f);
    for (int k = 1; k < NF; k++) begin
      f = up ? from + k : from - k;
      if (f >= 0 && f < NF && pend[f]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input bit rst_n, input bit cv, input int cf, input int cur, input bit stp);
    int t;
    int clr;
    bit ok;
    clr = -1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ok = cv && cf < NF;
    m_err = cv && cf >= NF;
    if (m_mode == M_IDLE) begin
      if (pend[cur]) begin
        clr = cur;
        m_mode = M_DWELL;
        m_left = DW;
        m_req = cur;
      end else if (seek(cur, m_up, t)) begin
        m_req = t;
        m_mode = M_MOVE;
      end else if (seek(cur, !m_up, t)) begin
        m_req = t;
        m_up = !m_up;
        m_mode = M_MOVE;
      end else m_req = cur;
    end else if (m_mode == M_MOVE) begin
      if (cur == m_req && stp) begin
        clr = m_req;
        m_mode = M_DWELL;
        m_left = DW;
      end else if (seek(cur, m_up, t) && (m_up ? t < m_req : t > m_req)) m_req = t;
    end else begin
      m_req = cur;
      if (ok && cf == cur) begin
        m_left = DW;
        ok = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    end
    if (ok && cf != clr) pend[cf] = 1'b1;
    if (clr >= 0) pend[clr] = 1'b0;
    m_busy = m_mode != M_IDLE;
  endtask

  task automatic step(input bit rst_n, input bit cv, input int cf);
    logic [NF-1:0] pv;
    @(negedge clk);
    if (cur_i != m_req) begin
      mv++;
      if (mv == 3) begin
        cur_i = m_req > cur_i ? cur_i + 1 : cur_i - 1;
        mv = 0;
      end
    end else mv = 0;
    cur_floor = FW'(cur_i);
    lift_stop = cur_i == m_req;
    reset = rst_n;
    call_valid = cv;
    call_floor = FW'(cf);
    @(posedge clk);
    model_step(rst_n, cv, cf, cur_i, lift_stop);
    #1;
    for (int i = 0; i < NF; i++) pv[i] = pend[i];
    check("req_floor", 32'(req_floor), 32'(m_req));
    check("pending", 32'(pending), 32'(pv));
    check("dir_up", 32'(dir_up), 32'(m_up));
    check("busy", 32'(busy), 32'(m_busy));
    check("call_err", 32'(call_err), 32'(m_err));
  endtask

  initial begin
    int r, cf;
    model_reset();
    cur_i = 0;
    mv = 0;
    repeat (2) step(1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    repeat (40) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 31);
    step(1'b1, 1'b1, 10);
    repeat (6) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 4);
    repeat (60) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b1, 9);
    repeat (12) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    repeat (20) step(1'b1, 1'b0, 0);
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 9);
      cf = r == 0 ? 31 + $urandom_range(0, 32) : r == 1 ? cur_i : $urandom_range(0, NF - 1);
      step($urandom_range(0, 399) != 0, $urandom_range(0, 4) == 0, cf);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
